// File: rtl/tdm_pkg.sv
// Shared constants and FSM state type for the 8-slot TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage : tdm_pkg

// File: rtl/tdm_demux1to8.sv
// Combinational decoder: a 3-bit slot index plus enable becomes a one-hot write-enable.
module demux1to8
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    sel_i,
  input  logic                 en_i,
  output logic [NUM_SLOTS-1:0] onehot_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule : demux1to8

// File: rtl/tdm_demux8.sv
// Splits a framed time-multiplexed word stream into eight held channel registers,
// tracking frame alignment with a HUNT/LOCKED FSM and flagging framing errors.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  input  logic                        frame_sync,
  output logic [NUM_SLOTS*DATA_W-1:0] ch_data,
  output logic [NUM_SLOTS-1:0]        ch_valid,
  output logic                        frame_done,
  output logic                        sync_err,
  output logic                        locked
);

  state_e                      state_q, state_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [NUM_SLOTS*DATA_W-1:0] ch_data_q;
  logic [NUM_SLOTS-1:0]        ch_valid_q;
  logic                        frame_done_q;
  logic                        sync_err_q, sync_err_d;
  logic                        wr_en;
  logic [SLOT_W-1:0]           wr_slot;
  logic [NUM_SLOTS-1:0]        wr_onehot;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    wr_en      = 1'b0;
    wr_slot    = slot_q;
    sync_err_d = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_sync) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = SLOT_W'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync anywhere but slot 0 realigns to the new frame but is still an error.
            sync_err_d = (slot_q != '0);
            wr_en      = 1'b1;
            wr_slot    = '0;
            slot_d     = SLOT_W'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            slot_d     = '0;
            state_d    = HUNT;
          end else begin
            wr_en  = 1'b1;
            slot_d = slot_q + SLOT_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  demux1to8 u_demux (
    .sel_i    (wr_slot),
    .en_i     (wr_en),
    .onehot_o (wr_onehot)
  );

  // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ch_valid_q   <= wr_onehot;
      frame_done_q <= wr_onehot[NUM_SLOTS-1];
      sync_err_q   <= sync_err_d;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (wr_onehot[k]) ch_data_q[k*DATA_W +: DATA_W] <= din;
      end
    end
  end

  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == LOCKED);

endmodule : tdm_demux8

// File: tb/tb_tdm_demux8.sv
// Directed self-checking bench for tdm_demux8 with hand-computed expected values.
module tb_tdm_demux8;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              frame_sync;
  logic [63:0]       ch_data;
  logic [7:0]        ch_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_count;

  tdm_demux8 #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input at the falling edge; return just after the capturing rising edge.
  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d);
    @(negedge clk);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic [7:0] v, input logic fd,
                               input logic se, input logic lk);
    check({tag, ".ch_valid"},   ch_valid,   v);
    check({tag, ".frame_done"}, frame_done, fd);
    check({tag, ".sync_err"},   sync_err,   se);
    check({tag, ".locked"},     locked,     lk);
  endtask

  initial begin
    rst_n      = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = '0;

    // Reset state
    #3;
    check("rst.ch_data", ch_data, 64'h0);
    check_strobes("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame at slot 4
    drive(1'b1, 1'b1, 8'hC0);
    for (int k = 1; k < 4; k++) drive(1'b1, 1'b0, 8'(8'hC0 + k));
    check("pre_rst.ch_data", ch_data, 64'h00000000_C3C2C1C0);
    #2;
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst.ch_data", ch_data, 64'h0);
    check_strobes("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'(8'hD0 + k));
      check_strobes("postrst", 8'h00, 1'b0, 1'b0, 1'b0);
      check("postrst.ch_data", ch_data, 64'h0);
    end

    // Clean frame 0x10..0x17
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k == 0, 8'(8'h10 + k));
      check_strobes("clean", 8'(1 << k), k == 7, 1'b0, 1'b1);
    end
    check("clean.ch_data", ch_data, 64'h17161514_13121110);

    // Two back-to-back frames wrap through slot 0
    fd_count = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, (k % 8) == 0, (k < 8) ? 8'(8'h20 + k) : 8'(8'h30 + k - 8));
      if (frame_done) fd_count++;
      check_strobes("wrap", 8'(1 << (k % 8)), (k % 8) == 7, 1'b0, 1'b1);
    end
    check("wrap.fd_count", fd_count, 2);
    check("wrap.ch_data", ch_data, 64'h37363534_33323130);

    // Gapped frame: two idle cycles between slots 3 and 4
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 8'(8'h10 + k));
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 8'hEE);
      check_strobes("gap.idle", 8'h00, 1'b0, 1'b0, 1'b1);
      check("gap.idle.ch_data", ch_data, 64'h37363534_13121110);
    end
    for (int k = 4; k < 8; k++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + k));
      check_strobes("gap", 8'(1 << k), k == 7, 1'b0, 1'b1);
    end
    check("gap.ch_data", ch_data, 64'h17161514_13121110);

    // Early sync at slot 5
    for (int k = 0; k < 5; k++) drive(1'b1, k == 0, 8'(8'h40 + k));
    drive(1'b1, 1'b1, 8'hAA);
    check_strobes("early", 8'h01, 1'b0, 1'b1, 1'b1);
    check("early.ch_data", ch_data, 64'h17161544_434241AA);
    drive(1'b1, 1'b0, 8'hBB);
    check_strobes("early.next", 8'h02, 1'b0, 1'b0, 1'b1);
    for (int k = 2; k < 8; k++) drive(1'b1, 1'b0, 8'(8'h50 + k));
    check("early.ch_data2", ch_data, 64'h57565554_5352BBAA);

    // Missing sync after slot 7
    drive(1'b1, 1'b0, 8'h55);
    check_strobes("miss", 8'h00, 1'b0, 1'b1, 1'b0);
    check("miss.ch_data", ch_data, 64'h57565554_5352BBAA);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 8'h66);
      check_strobes("miss.after", 8'h00, 1'b0, 1'b0, 1'b0);
      check("miss.after.ch_data", ch_data, 64'h57565554_5352BBAA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tdm_demux8
